// File: rtl/riscv_pkg.sv
// riscv_pkg: memory-stage encodings, LSU state type and byte-enable helper
package riscv_pkg;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_SB   = 2'b01;
  localparam logic [1:0] MEM_SH   = 2'b10;
  localparam logic [1:0] MEM_SW   = 2'b11;
  localparam logic [2:0] EXT_LW  = 3'b000;
  localparam logic [2:0] EXT_LB  = 3'b001;
  localparam logic [2:0] EXT_LH  = 3'b010;
  localparam logic [2:0] EXT_LBU = 3'b101;
  localparam logic [2:0] EXT_LHU = 3'b110;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
  // size uses the MEM_* codes: byte, half or word
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    return size == MEM_SB ? 4'b0001 << offset : size == MEM_SH ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/load_extender.sv
// load_extender: selects the addressed lane of a read word and sign/zero-extends it
module load_extender
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  extend,
  output logic [31:0] result
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  // lane select then extension; unknown extend codes fall through to the full word
  always_comb begin
    lane_b = word[8*offset +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    result = extend == EXT_LB  ? {{24{lane_b[7]}}, lane_b} :
             extend == EXT_LBU ? {24'b0, lane_b} :
             extend == EXT_LH  ? {{16{lane_h[15]}}, lane_h} :
             extend == EXT_LHU ? {16'b0, lane_h} : word;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access FSM with store formatting and load extension
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [1:0]  memory_write_i,
  input  logic        result_source_i,
  input  logic [2:0]  result_extend_control_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic        stall_o,
  output logic [31:0] read_data_o,
  output logic        read_valid_o,
  output logic        misaligned_o,
  output logic        error_o,
  output logic        bus_request_o,
  output logic        bus_write_o,
  output logic [31:0] bus_address_o,
  output logic [3:0]  bus_byte_enable_o,
  output logic [31:0] bus_write_data_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_read_data_i
);
  lsu_state_t               state;
  logic [COUNTER_WIDTH-1:0] count;
  logic [2:0]               ext_q;
  logic [1:0]               off_q;
  logic                     is_load_q;
  logic                     is_store;
  logic                     access;
  logic                     misaligned;
  logic                     timeout;
  logic [1:0]               size;
  logic [31:0]              store_data;
  logic [31:0]              ext_data;
  // decode the incoming instruction; a store wins over a simultaneous load
  always_comb begin
    is_store   = memory_write_i != MEM_NONE;
    access     = valid_i & (is_store | result_source_i);
    size       = is_store ? memory_write_i :
                 result_extend_control_i[1:0] == 2'b01 ? MEM_SB :
                 result_extend_control_i[1:0] == 2'b10 ? MEM_SH : MEM_SW;
    misaligned = (size == MEM_SH & address_i[0]) | (size == MEM_SW & |address_i[1:0]);
    store_data = memory_write_i == MEM_SB ? {4{write_data_i[7:0]}} :
                 memory_write_i == MEM_SH ? {2{write_data_i[15:0]}} : write_data_i;
    timeout    = TIMEOUT_CYCLES != 0 && count == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  end
  assign stall_o       = state == BUSY | (state == IDLE & access & ~misaligned);
  assign misaligned_o  = state == IDLE & access & misaligned;
  assign bus_request_o = state == BUSY;
  load_extender u_ext (
    .word   (bus_read_data_i),
    .offset (off_q),
    .extend (ext_q),
    .result (ext_data)
  );
  // access FSM: latch request in IDLE, wait for ready or timeout in BUSY, report in DONE
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state             <= IDLE;
      count             <= '0;
      ext_q             <= EXT_LW;
      off_q             <= '0;
      is_load_q         <= 1'b0;
      read_data_o       <= '0;
      read_valid_o      <= 1'b0;
      error_o           <= 1'b0;
      bus_write_o       <= 1'b0;
      bus_address_o     <= '0;
      bus_byte_enable_o <= '0;
      bus_write_data_o  <= '0;
    end else begin
      read_valid_o <= 1'b0;
      error_o      <= 1'b0;
      case (state)
        IDLE: if (access & ~misaligned) begin
          state             <= BUSY;
          count             <= '0;
          bus_address_o     <= {address_i[31:2], 2'b00};
          bus_write_o       <= is_store;
          bus_byte_enable_o <= byte_enables(size, address_i[1:0]);
          bus_write_data_o  <= store_data;
          ext_q             <= result_extend_control_i;
          off_q             <= address_i[1:0];
          is_load_q         <= ~is_store;
        end
        BUSY: begin
          count <= count + 1'b1;
          if (bus_ready_i | timeout) begin
            state        <= DONE;
            read_valid_o <= is_load_q;
            error_o      <= ~bus_ready_i;
            if (is_load_q) read_data_o <= bus_ready_i ? ext_data : '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end
endmodule
